// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Packet mode is enabled by defining STREAM_MUX_RR_PKT_EN.
package stream_mux_rr_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   // Pointer width: enough bits to index N channels, never less than one.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Rotating-priority one-hot arbiter: grants the first requester found when
// scanning from ptr upwards and wrapping to channel 0.
module rr_arb
   import stream_mux_rr_pkg::*;
#(
   parameter int N  = 4,
   localparam int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;
   int   ptr_i;

   // NOTE: every signal written here gets a default first, so no path
   // through the block can leave a value held and infer a latch.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      ptr_i = int'(ptr);
      // Upper segment first (ptr..N-1), then the wrapped segment (0..ptr-1).
      for (int c = 0; c < N; c++) begin
         if (!found && req[c] && (c >= ptr_i)) begin
            gnt[c] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int c = 0; c < N; c++) begin
         if (!found && req[c] && (c < ptr_i)) begin
            gnt[c] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N:1 valid/ready stream mux with round-robin arbitration.
// Define STREAM_MUX_RR_PKT_EN to hold the grant for whole packets (i_x_last).
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                arst,
   input  logic [N-1:0]        i_x_vld,
   input  logic [N-1:0][W-1:0] i_x_data,
   input  logic [N-1:0]        i_x_last,
   output logic [N-1:0]        o_x_rdy,
   output logic                o_y_vld,
   output logic [W-1:0]        o_y_data,
   output logic                o_y_last,
   output logic [N-1:0]        o_y_sel,
   input  logic                i_y_rdy
);

   localparam int PW = ptr_width(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic [N-1:0]  arb_gnt;
   logic [N-1:0]  gnt;
   logic [PW-1:0] gnt_idx;
   logic          can_accept;
   logic          accept;
   logic [W-1:0]  sel_data;
   logic          sel_last;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(N - 1)) ? '0 : p + PW'(1);
   endfunction

   rr_arb #(.N(N)) u_arb (
      .req (i_x_vld),
      .ptr (ptr),
      .gnt (arb_gnt)
   );

   assign can_accept = ~o_y_vld | i_y_rdy;
   assign o_x_rdy    = gnt & {N{can_accept}};
   assign accept     = |(i_x_vld & o_x_rdy);

   always_comb begin
      gnt_idx = '0;
      for (int c = 0; c < N; c++) begin
         if (gnt[c]) gnt_idx = PW'(c);
      end
   end

   // AND-OR select: unselected lanes are masked to zero, so X on idle
   // channels never reaches the output register.
   always_comb begin
      sel_data = '0;
      for (int c = 0; c < N; c++) begin
         sel_data = sel_data | ({W{gnt[c]}} & i_x_data[c]);
      end
   end

`ifdef STREAM_MUX_RR_PKT_EN
   lock_state_e   state;
   lock_state_e   state_nxt;
   logic [PW-1:0] lock_ch;
   logic [PW-1:0] lock_ch_nxt;

   assign sel_last = |(gnt & i_x_last);

   // While locked the grant stays on the packet's channel even if it idles.
   always_comb begin
      gnt = arb_gnt;
      if (state == LOCKED) begin
         for (int c = 0; c < N; c++) begin
            gnt[c] = (lock_ch == PW'(c));
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      lock_ch_nxt = lock_ch;
      ptr_nxt     = ptr;
      case (state)
         IDLE: begin
            if (accept) begin
               ptr_nxt = wrap_inc(gnt_idx);
               if (!sel_last) begin
                  state_nxt   = LOCKED;
                  lock_ch_nxt = gnt_idx;
               end
            end
         end
         LOCKED: begin
            if (accept && sel_last) begin
               ptr_nxt   = wrap_inc(lock_ch);
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= IDLE;
         lock_ch <= '0;
      end else begin
         state   <= state_nxt;
         lock_ch <= lock_ch_nxt;
      end
   end
`else
   logic unused_last;

   assign unused_last = ^i_x_last;
   assign gnt         = arb_gnt;
   assign sel_last    = 1'b0;
   assign ptr_nxt     = accept ? wrap_inc(gnt_idx) : ptr;
`endif

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) ptr <= '0;
      else      ptr <= ptr_nxt;
   end

   // The data register has a defined reset value, so it is reset like the rest.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         o_y_vld  <= 1'b0;
         o_y_data <= '0;
         o_y_last <= 1'b0;
         o_y_sel  <= '0;
      end else if (accept) begin
         o_y_vld  <= 1'b1;
         o_y_data <= sel_data;
         o_y_last <= sel_last;
         o_y_sel  <= gnt;
      end else if (i_y_rdy) begin
         o_y_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4 and N=3 instances); packet-mode
// cases run only when STREAM_MUX_RR_PKT_EN is defined.
module tb_stream_mux_rr;

`ifdef STREAM_MUX_RR_PKT_EN
   localparam bit PKT = 1'b1;
`else
   localparam bit PKT = 1'b0;
`endif

   logic clk  = 1'b0;
   logic arst = 1'b1;

   logic [3:0]        v  = '0;
   logic [3:0][31:0]  d  = '0;
   logic [3:0]        l  = '0;
   logic              yr = 1'b0;
   logic [3:0]        rdy;
   logic              y_vld;
   logic [31:0]       y_data;
   logic              y_last;
   logic [3:0]        y_sel;

   logic [2:0]        v3  = '0;
   logic [2:0][31:0]  d3  = '0;
   logic [2:0]        l3  = '0;
   logic              yr3 = 1'b0;
   logic [2:0]        rdy3;
   logic              y_vld3;
   logic [31:0]       y_data3;
   logic              y_last3;
   logic [2:0]        y_sel3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.N(4), .W(32)) dut4 (
      .clk(clk), .arst(arst), .i_x_vld(v), .i_x_data(d), .i_x_last(l),
      .o_x_rdy(rdy), .o_y_vld(y_vld), .o_y_data(y_data), .o_y_last(y_last),
      .o_y_sel(y_sel), .i_y_rdy(yr)
   );

   stream_mux_rr #(.N(3), .W(32)) dut3 (
      .clk(clk), .arst(arst), .i_x_vld(v3), .i_x_data(d3), .i_x_last(l3),
      .o_x_rdy(rdy3), .o_y_vld(y_vld3), .o_y_data(y_data3), .o_y_last(y_last3),
      .o_y_sel(y_sel3), .i_y_rdy(yr3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the visible output beat plus the arbitration state.
   typedef struct {
      int          ptr;
      bit          vld;
      logic [31:0] data;
      logic [3:0]  sel;
      bit          last;
      bit          locked;
      int          lock;
   } mdl_t;

   function automatic mdl_t m_reset();
      mdl_t m;
      m.ptr = 0; m.vld = 0; m.data = '0; m.sel = '0;
      m.last = 0; m.locked = 0; m.lock = 0;
      return m;
   endfunction

   function automatic logic [3:0] m_grant(input mdl_t m, input int n, input logic [3:0] req);
      logic [3:0] gr;
      gr = '0;
      if (PKT && m.locked) begin
         gr[m.lock] = 1'b1;
         return gr;
      end
      for (int k = 0; k < n; k++) begin
         if (req[(m.ptr + k) % n]) begin
            gr[(m.ptr + k) % n] = 1'b1;
            return gr;
         end
      end
      return gr;
   endfunction

   function automatic mdl_t m_step(input mdl_t m, input int n, input logic [3:0] req,
                                   input logic [3:0][31:0] dat, input logic [3:0] lst,
                                   input bit y_rdy);
      mdl_t       nx;
      logic [3:0] gr;
      int         j;
      nx = m;
      j  = -1;
      gr = (!m.vld || y_rdy) ? m_grant(m, n, req) : 4'b0000;
      for (int c = 0; c < n; c++) if (gr[c] && req[c]) j = c;
      if (j >= 0) begin
         nx.vld  = 1;
         nx.data = dat[j];
         nx.sel  = gr;
         nx.last = PKT ? lst[j] : 1'b0;
         if (!PKT) begin
            nx.ptr = (j + 1) % n;
         end else if (!m.locked) begin
            nx.ptr = (j + 1) % n;
            if (!lst[j]) begin
               nx.locked = 1;
               nx.lock   = j;
            end
         end else if (lst[j]) begin
            nx.ptr    = (m.lock + 1) % n;
            nx.locked = 0;
         end
      end else if (y_rdy) begin
         nx.vld = 0;
      end
      return nx;
   endfunction

   mdl_t m4 = m_reset();
   mdl_t m3 = m_reset();

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      logic [3:0]       exp_rdy;
      logic [3:0][31:0] dd;
      if (arst) begin
         m4 = m_reset();
         m3 = m_reset();
      end else begin
         exp_rdy = (!m4.vld || yr) ? m_grant(m4, 4, v) : 4'b0000;
         check("n4_rdy",  rdy,    exp_rdy);
         check("n4_vld",  y_vld,  m4.vld);
         check("n4_last", y_last, m4.last);
         check("n4_sel",  y_sel,  m4.sel);
         if (m4.vld) check("n4_data", y_data, m4.data);
         m4 = m_step(m4, 4, v, d, l, yr);

         dd = '0;
         for (int c = 0; c < 3; c++) dd[c] = d3[c];
         exp_rdy = (!m3.vld || yr3) ? m_grant(m3, 3, {1'b0, v3}) : 4'b0000;
         check("n3_rdy",  rdy3,    exp_rdy);
         check("n3_vld",  y_vld3,  m3.vld);
         check("n3_last", y_last3, m3.last);
         check("n3_sel",  y_sel3,  m3.sel);
         if (m3.vld) check("n3_data", y_data3, m3.data);
         m3 = m_step(m3, 3, {1'b0, v3}, dd, {1'b0, l3}, yr3);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset, idle inputs.
      repeat (2) @(posedge clk);
      #2 arst = 1'b0;
      tick();
      #1;
      check("rst_vld",  y_vld,  1'b0);
      check("rst_data", y_data, 32'h0);
      check("rst_sel",  y_sel,  4'b0000);
      check("rst_rdy",  rdy,    4'b0000);

      // All channels valid, consumer always ready: ch0,1,2,3,0.
      for (int c = 0; c < 4; c++) d[c] = 32'hA0 + c;
      l  = 4'b1111;
      v  = 4'b1111;
      yr = 1'b1;
      #1 check("rr_first_rdy", rdy, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_data", y_data, 32'hA0 + (k % 4));
         check("rr_vld",  y_vld,  1'b1);
      end

      // Only ch2 valid, idle lanes carry X, then 3 cycles of back-pressure.
      v = 4'b0100;
      l = 4'b0100;
      d[0] = 'x; d[1] = 'x; d[3] = 'x;
      tick();
      check("bp_first", y_data, 32'hA2);
      yr = 1'b0;
      #1 check("bp_rdy0", rdy, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_hold_data", y_data, 32'hA2);
         check("bp_hold_vld",  y_vld,  1'b1);
         check("bp_hold_rdy",  rdy,    4'b0000);
      end
      yr = 1'b1;
      #1 check("bp_release_rdy", rdy, 4'b0100);
      tick();
      check("bp_nobubble_vld", y_vld, 1'b1);
      check("bp_nobubble_sel", y_sel, 4'b0100);
      v = 4'b0000;
      tick();
      check("bp_drain", y_vld, 1'b0);
      for (int c = 0; c < 4; c++) d[c] = 32'hA0 + c;

      // N=3: ch1 moves ptr to 2, then ch2 and ch0 requested -> 2, 0, and wrap.
      for (int c = 0; c < 3; c++) d3[c] = 32'hB0 + c;
      l3  = 3'b111;
      yr3 = 1'b1;
      v3  = 3'b010;
      #1 check("n3_rdy_ch1", rdy3, 3'b010);
      tick();
      check("n3_sel_ch1", y_sel3, 3'b010);
      v3 = 3'b101;
      #1 check("n3_rdy_ch2", rdy3, 3'b100);
      tick();
      check("n3_sel_ch2",  y_sel3,  3'b100);
      check("n3_data_ch2", y_data3, 32'hB2);
      tick();
      check("n3_sel_wrap", y_sel3,  3'b001);
      check("n3_data_ch0", y_data3, 32'hB0);
      v3 = 3'b111;
      tick();
      check("n3_sel_ptr1", y_sel3, 3'b010);
      v3 = 3'b000;
      tick();

`ifdef STREAM_MUX_RR_PKT_EN
      // Single-beat ch0 leaves ptr at 1; then a 3-beat ch1 packet beside ch0.
      v = 4'b0001; l = 4'b0001;
      tick();
      v = 4'b0011; l = 4'b0001; d[1] = 32'hC0;
      #1 check("pk_rdy_start", rdy, 4'b0010);
      tick();
      check("pk_b0", y_data, 32'hC0);
      d[1] = 32'hC1;
      #1 check("pk_rdy_lock", rdy, 4'b0010);
      tick();
      check("pk_b1", y_data, 32'hC1);
      check("pk_b1_sel", y_sel, 4'b0010);
      d[1] = 32'hC2; l = 4'b0011;
      tick();
      check("pk_b2", y_data, 32'hC2);
      check("pk_b2_last", y_last, 1'b1);
      #1 check("pk_rdy_release", rdy, 4'b0001);
      tick();
      check("pk_ch0_after", y_sel, 4'b0001);

      // Same packet, but ch1 idles mid-packet: ch0 must stay blocked.
      l = 4'b0001; d[1] = 32'hD0;
      tick();
      check("pk2_b0", y_data, 32'hD0);
      v = 4'b0001;
      #1 check("pk2_forced_rdy", rdy, 4'b0010);
      tick();
      check("pk2_gap_vld", y_vld, 1'b0);
      check("pk2_gap_rdy", rdy, 4'b0010);
      tick();
      v = 4'b0011; d[1] = 32'hD1; l = 4'b0011;
      tick();
      check("pk2_b1", y_data, 32'hD1);
      check("pk2_b1_sel", y_sel, 4'b0010);
      tick();
      check("pk2_ch0_after", y_sel, 4'b0001);
      v = 4'b0000; l = 4'b0000;
      tick();
`endif

      // Reset while a beat is held (and, in packet mode, while LOCKED on ch1).
      v = 4'b0010; l = 4'b0000; d[1] = 32'hE0;
      tick();
      check("ar_pre_vld", y_vld, 1'b1);
      check("ar_pre_sel", y_sel, 4'b0010);
      arst = 1'b1;
      #1;
      check("ar_vld",  y_vld,  1'b0);
      check("ar_sel",  y_sel,  4'b0000);
      check("ar_data", y_data, 32'h0);
      @(posedge clk);
      #2 arst = 1'b0;
      v = 4'b0011; l = 4'b0011; d[0] = 32'hA0;
      #1 check("ar_rdy_ch0", rdy, 4'b0001);
      tick();
      check("ar_sel_ch0",  y_sel,  4'b0001);
      check("ar_data_ch0", y_data, 32'hA0);
      v = 4'b0000;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
